// File: rtl/stepper_phase_sequencer.sv
// Half-step phase sequencer for the paper-feed stepper: runs 4 half-steps per dot line
// at a programmable rate, in either direction, and pulses done when the move ends.
module stepper_phase_sequencer #(
  parameter int PERIOD_W = 16,
  parameter int LINES_W  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LINES_W-1:0]  cmd_lines,
  input  logic                cmd_reverse,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic                hold_enable,
  input  logic                abort,
  output logic                motor_phase_a,
  output logic                motor_phase_b,
  output logic                motor_phase_na,
  output logic                motor_phase_nb,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LINES_W-1:0]  lines_moved,
  output logic                o_dbg_state
);

  // Command handshake: a command is taken on any edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly while IDLE, and nothing is queued while RUN.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state, w_state;
  logic [2:0]            r_idx, w_idx, w_idx_step;
  logic [3:0]            r_phase, w_phase;
  logic                  r_rev, w_rev;
  logic [PERIOD_W-1:0]   r_period_m1, w_period_m1;
  logic [PERIOD_W-1:0]   r_timer, w_timer;
  logic [LINES_W+1:0]    r_steps, w_steps;
  logic [LINES_W-1:0]    r_lines, w_lines;
  logic                  r_done, w_done;
  logic                  r_aborted, w_aborted;
  logic [3:0]            w_idle_phase;

  function automatic logic [3:0] step_pat(input logic [2:0] i);
    case (i)
      3'd0:    step_pat = 4'b1000;
      3'd1:    step_pat = 4'b1100;
      3'd2:    step_pat = 4'b0100;
      3'd3:    step_pat = 4'b0110;
      3'd4:    step_pat = 4'b0010;
      3'd5:    step_pat = 4'b0011;
      3'd6:    step_pat = 4'b0001;
      default: step_pat = 4'b1001;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_phase     <= '0;
      r_rev       <= 1'b0;
      r_period_m1 <= '0;
      r_timer     <= '0;
      r_steps     <= '0;
      r_lines     <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_phase     <= w_phase;
      r_rev       <= w_rev;
      r_period_m1 <= w_period_m1;
      r_timer     <= w_timer;
      r_steps     <= w_steps;
      r_lines     <= w_lines;
      r_done      <= w_done;
      r_aborted   <= w_aborted;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_phase      = r_phase;
    w_rev        = r_rev;
    w_period_m1  = r_period_m1;
    w_timer      = r_timer;
    w_steps      = r_steps;
    w_lines      = r_lines;
    w_done       = 1'b0;
    w_aborted    = r_aborted;
    w_idx_step   = r_rev ? (r_idx - 3'd1) : (r_idx + 3'd1);
    w_idle_phase = hold_enable ? step_pat(r_idx) : 4'b0000;

    case (r_state)
      S_IDLE: begin
        w_phase = w_idle_phase;
        if (cmd_valid) begin
          w_rev       = cmd_reverse;
          w_period_m1 = (step_period == '0) ? '0 : (step_period - 1'b1);
          w_steps     = {cmd_lines, 2'b00};
          w_lines     = '0;
          w_aborted   = 1'b0;
          if (cmd_lines == '0) begin
            w_done = 1'b1;
          end else begin
            w_state = S_RUN;
            w_phase = step_pat(r_idx);
            w_timer = w_period_m1;
          end
        end
      end
      default: begin
        if (abort) begin
          // Stop on the pattern currently driven; no extra step is taken.
          w_state   = S_IDLE;
          w_done    = 1'b1;
          w_aborted = 1'b1;
          w_phase   = w_idle_phase;
        end else if (r_timer == '0) begin
          if (r_steps == '0) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
            w_phase = w_idle_phase;
          end else begin
            w_idx   = w_idx_step;
            w_phase = step_pat(w_idx_step);
            w_steps = r_steps - 1'b1;
            w_timer = r_period_m1;
            // The step that leaves a multiple of 4 remaining completes a line.
            if (r_steps[1:0] == 2'b01 && r_lines != '1) begin
              w_lines = r_lines + 1'b1;
            end
          end
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end
    endcase
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state == S_RUN);
  assign o_dbg_state    = r_state;
  assign done           = r_done;
  assign aborted        = r_aborted;
  assign lines_moved    = r_lines;
  assign motor_phase_a  = r_phase[3];
  assign motor_phase_b  = r_phase[2];
  assign motor_phase_na = r_phase[1];
  assign motor_phase_nb = r_phase[0];

endmodule
